// File: rtl/rgb_filt_sched.sv
// Frame-synchronous filter-enable scheduler: holds a new config until a frame boundary,
// stalls p0, drains in-flight beats under the old config, then switches atomically.
module rgb_filt_sched #(
    parameter int unsigned Depth         = 4,
    parameter int unsigned FramesPerMode = 60,
    parameter logic [3:0]  ResetEnable   = 4'b0000,
    localparam int unsigned OccW         = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_valid_i,
    output logic            cfg_ready_o,
    input  logic [3:0]      cfg_enable_i,
    input  logic            auto_en_i,
    input  logic            in_valid_i,
    input  logic            in_ready_i,
    input  logic            vsync_i,
    input  logic            out_valid_i,
    input  logic            out_ready_i,
    output logic            stall_o,
    output logic [3:0]      filt_enable_o,
    output logic            busy_o,
    output logic [OccW-1:0] occupancy_o,
    output logic            err_o,
    output logic [1:0]      state_o
);

    localparam int unsigned FcW = $clog2(FramesPerMode + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2,
        APPLY = 2'd3
    } state_t;

    // Handshakes: a beat transfers on a clock edge where valid and ready are both high;
    // p0 ready is additionally gated by ~stall_o while a switch is in progress.
    state_t         state;
    logic [3:0]     pend;
    logic [FcW-1:0] frame_cnt;
    logic [FcW-1:0] fc_next;
    logic           vs_prev;
    logic           in_fire;
    logic           out_fire;
    logic           fb;

    assign in_fire  = in_valid_i & in_ready_i & ~stall_o;
    assign out_fire = out_valid_i & out_ready_i;
    assign fb       = in_fire & vsync_i & ~vs_prev;
    assign fc_next  = frame_cnt + FcW'(1);

    // Pure decodes of the state flops, so stall_o has no path from any input.
    assign stall_o     = (state == DRAIN) || (state == APPLY);
    assign busy_o      = (state != IDLE);
    assign cfg_ready_o = (state == IDLE);
    assign state_o     = state;

    // Occupancy saturates on misuse and flags it, rather than wrapping silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occupancy_o <= '0;
            err_o       <= 1'b0;
        end else if (in_fire && !out_fire) begin
            if (occupancy_o == OccW'(Depth)) err_o <= 1'b1;
            else                             occupancy_o <= occupancy_o + OccW'(1);
        end else if (out_fire && !in_fire) begin
            if (occupancy_o == '0) err_o <= 1'b1;
            else                   occupancy_o <= occupancy_o - OccW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      vs_prev <= 1'b0;
        else if (in_fire) vs_prev <= vsync_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            pend          <= 4'd0;
            frame_cnt     <= '0;
            filt_enable_o <= ResetEnable;
        end else begin
            case (state)
                IDLE: begin
                    // An explicit request wins over an auto step landing in the same cycle.
                    if (cfg_valid_i) begin
                        pend      <= cfg_enable_i;
                        frame_cnt <= '0;
                        state     <= ARMED;
                    end else if (auto_en_i && fb) begin
                        if (fc_next == FcW'(FramesPerMode)) begin
                            pend      <= filt_enable_o + 4'd1;
                            frame_cnt <= '0;
                            state     <= ARMED;
                        end else begin
                            frame_cnt <= fc_next;
                        end
                    end
                end
                ARMED: begin
                    if (fb) state <= DRAIN;
                end
                DRAIN: begin
                    if (occupancy_o == '0) state <= APPLY;
                end
                APPLY: begin
                    filt_enable_o <= pend;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_filt_sched.sv
// Directed bench for rgb_filt_sched with FramesPerMode=2; each scenario task checks inline.
module tb_rgb_filt_sched;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_APPLY = 2'd3;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cfg_valid_i = 1'b0;
    logic       cfg_ready_o;
    logic [3:0] cfg_enable_i = 4'd0;
    logic       auto_en_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_i = 1'b1;
    logic       vsync_i = 1'b0;
    logic       out_valid_i = 1'b0;
    logic       out_ready_i = 1'b1;
    logic       stall_o;
    logic [3:0] filt_enable_o;
    logic       busy_o;
    logic [2:0] occupancy_o;
    logic       err_o;
    logic [1:0] state_o;

    int checks = 0;
    int failures = 0;

    rgb_filt_sched #(
        .Depth(4),
        .FramesPerMode(2),
        .ResetEnable(4'b0000)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_enable_i(cfg_enable_i),
        .auto_en_i(auto_en_i),
        .in_valid_i(in_valid_i),
        .in_ready_i(in_ready_i),
        .vsync_i(vsync_i),
        .out_valid_i(out_valid_i),
        .out_ready_i(out_ready_i),
        .stall_o(stall_o),
        .filt_enable_o(filt_enable_o),
        .busy_o(busy_o),
        .occupancy_o(occupancy_o),
        .err_o(err_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs re-driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        cfg_valid_i = 1'b0; cfg_enable_i = 4'd0; auto_en_i = 1'b0;
        in_valid_i = 1'b0; in_ready_i = 1'b1; vsync_i = 1'b0;
        out_valid_i = 1'b0; out_ready_i = 1'b1;
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic beat(input logic vs, input logic ov);
        in_valid_i = 1'b1; vsync_i = vs; out_valid_i = ov;
        tick();
        in_valid_i = 1'b0; vsync_i = 1'b0; out_valid_i = 1'b0;
    endtask

    // One frame: a plain beat, a vsync beat (the boundary) with an exit, then one more exit.
    task automatic send_frame();
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b1);
        out_valid_i = 1'b1;
        tick();
        out_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_o); end
        checks++; if (filt_enable_o !== 4'h0) begin failures++; $display("FAIL reset_enable got=%h exp=0", filt_enable_o); end
        rst_ni = 1'b1;
        tick();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%0b exp=1", cfg_ready_o); end
        checks++; if (occupancy_o !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        checks++; if (state_o !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_IDLE); end
    endtask

    task automatic test_explicit();
        apply_reset();
        cfg_valid_i = 1'b1; cfg_enable_i = 4'hA;
        tick();
        cfg_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL expl_busy got=%0b exp=1", busy_o); end
        checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL expl_cfg_ready got=%0b exp=0", cfg_ready_o); end
        checks++; if (state_o !== S_ARMED) begin failures++; $display("FAIL expl_armed got=%0d exp=%0d", state_o, S_ARMED); end
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b0);
            checks++; if (occupancy_o !== 3'(i + 1)) begin failures++; $display("FAIL expl_fill_occ got=%0d exp=%0d", occupancy_o, i + 1); end
            checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL expl_fill_stall got=%0b exp=0", stall_o); end
        end
        beat(1'b1, 1'b0);
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL expl_stall_rise got=%0b exp=1", stall_o); end
        checks++; if (occupancy_o !== 3'd4) begin failures++; $display("FAIL expl_occ_full got=%0d exp=4", occupancy_o); end
        checks++; if (state_o !== S_DRAIN) begin failures++; $display("FAIL expl_drain got=%0d exp=%0d", state_o, S_DRAIN); end
        // A beat keeps being offered at p0; the stall must keep it out.
        in_valid_i = 1'b1; vsync_i = 1'b0; out_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (occupancy_o !== 3'(3 - i)) begin failures++; $display("FAIL expl_drain_occ got=%0d exp=%0d", occupancy_o, 3 - i); end
            checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL expl_drain_stall got=%0b exp=1", stall_o); end
            checks++; if (filt_enable_o !== 4'h0) begin failures++; $display("FAIL expl_drain_enable got=%h exp=0", filt_enable_o); end
        end
        out_valid_i = 1'b0;
        checks++; if (state_o !== S_DRAIN) begin failures++; $display("FAIL expl_drain_empty got=%0d exp=%0d", state_o, S_DRAIN); end
        tick();
        checks++; if (state_o !== S_APPLY) begin failures++; $display("FAIL expl_apply got=%0d exp=%0d", state_o, S_APPLY); end
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL expl_apply_stall got=%0b exp=1", stall_o); end
        checks++; if (filt_enable_o !== 4'h0) begin failures++; $display("FAIL expl_apply_enable got=%h exp=0", filt_enable_o); end
        tick();
        in_valid_i = 1'b0;
        checks++; if (filt_enable_o !== 4'hA) begin failures++; $display("FAIL expl_switch got=%h exp=a", filt_enable_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL expl_stall_fall got=%0b exp=0", stall_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL expl_idle_busy got=%0b exp=0", busy_o); end
        checks++; if (occupancy_o !== 3'd0) begin failures++; $display("FAIL expl_no_leak got=%0d exp=0", occupancy_o); end
        beat(1'b0, 1'b0);
        checks++; if (occupancy_o !== 3'd1) begin failures++; $display("FAIL expl_first_new got=%0d exp=1", occupancy_o); end
    endtask

    task automatic test_auto_cycle();
        apply_reset();
        auto_en_i = 1'b1;
        for (int s = 1; s <= 2; s++) begin
            send_frame();
            checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL auto_count_busy step=%0d got=%0b exp=0", s, busy_o); end
            send_frame();
            checks++; if (state_o !== S_ARMED) begin failures++; $display("FAIL auto_armed step=%0d got=%0d exp=%0d", s, state_o, S_ARMED); end
            send_frame();
            checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL auto_stall step=%0d got=%0b exp=1", s, stall_o); end
            checks++; if (filt_enable_o !== 4'(s - 1)) begin failures++; $display("FAIL auto_old step=%0d got=%h exp=%h", s, filt_enable_o, s - 1); end
            tick();
            tick();
            checks++; if (filt_enable_o !== 4'(s)) begin failures++; $display("FAIL auto_new step=%0d got=%h exp=%h", s, filt_enable_o, s); end
            checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL auto_release step=%0d got=%0b exp=0", s, stall_o); end
        end
    endtask

    task automatic test_auto_wrap();
        apply_reset();
        cfg_valid_i = 1'b1; cfg_enable_i = 4'hF;
        tick();
        cfg_valid_i = 1'b0;
        send_frame();
        tick();
        tick();
        checks++; if (filt_enable_o !== 4'hF) begin failures++; $display("FAIL wrap_start got=%h exp=f", filt_enable_o); end
        auto_en_i = 1'b1;
        send_frame();
        send_frame();
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL wrap_armed got=%0b exp=1", busy_o); end
        send_frame();
        tick();
        tick();
        checks++; if (filt_enable_o !== 4'h0) begin failures++; $display("FAIL wrap_result got=%h exp=0", filt_enable_o); end
    endtask

    task automatic test_priority();
        apply_reset();
        auto_en_i = 1'b1;
        send_frame();
        beat(1'b0, 1'b0);
        cfg_valid_i = 1'b1; cfg_enable_i = 4'h5;
        beat(1'b1, 1'b1);
        cfg_valid_i = 1'b0;
        out_valid_i = 1'b1;
        tick();
        out_valid_i = 1'b0;
        checks++; if (state_o !== S_ARMED) begin failures++; $display("FAIL prio_armed got=%0d exp=%0d", state_o, S_ARMED); end
        send_frame();
        tick();
        tick();
        checks++; if (filt_enable_o !== 4'h5) begin failures++; $display("FAIL prio_cfg_wins got=%h exp=5", filt_enable_o); end
        send_frame();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL prio_cnt_cleared got=%0b exp=0", busy_o); end
        send_frame();
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL prio_auto_armed got=%0b exp=1", busy_o); end
        // An already-armed auto step still applies after auto is switched off.
        auto_en_i = 1'b0;
        send_frame();
        tick();
        tick();
        checks++; if (filt_enable_o !== 4'h6) begin failures++; $display("FAIL prio_armed_applies got=%h exp=6", filt_enable_o); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        cfg_valid_i = 1'b1; cfg_enable_i = 4'h3;
        tick();
        cfg_valid_i = 1'b0;
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        in_valid_i = 1'b1; out_valid_i = 1'b1; out_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL bp_stall cyc=%0d got=%0b exp=1", i, stall_o); end
            checks++; if (filt_enable_o !== 4'h0) begin failures++; $display("FAIL bp_enable cyc=%0d got=%h exp=0", i, filt_enable_o); end
            checks++; if (occupancy_o !== 3'd3) begin failures++; $display("FAIL bp_occ cyc=%0d got=%0d exp=3", i, occupancy_o); end
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (occupancy_o !== 3'(2 - i)) begin failures++; $display("FAIL bp_drain_occ got=%0d exp=%0d", occupancy_o, 2 - i); end
        end
        out_valid_i = 1'b0;
        tick();
        checks++; if (filt_enable_o !== 4'h0) begin failures++; $display("FAIL bp_last_plus1 got=%h exp=0", filt_enable_o); end
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL bp_last_plus1_stall got=%0b exp=1", stall_o); end
        tick();
        in_valid_i = 1'b0;
        checks++; if (filt_enable_o !== 4'h3) begin failures++; $display("FAIL bp_last_plus2 got=%h exp=3", filt_enable_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b exp=0", stall_o); end
    endtask

    task automatic test_occupancy();
        apply_reset();
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        in_valid_i = 1'b1; out_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            vsync_i = (i % 2 == 1);
            tick();
            checks++; if (occupancy_o !== 3'd2) begin failures++; $display("FAIL occ_steady cyc=%0d got=%0d exp=2", i, occupancy_o); end
        end
        in_valid_i = 1'b0; out_valid_i = 1'b0; vsync_i = 1'b0;
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL occ_steady_err got=%0b exp=0", err_o); end
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        checks++; if (occupancy_o !== 3'd4) begin failures++; $display("FAIL occ_full got=%0d exp=4", occupancy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL occ_full_err got=%0b exp=0", err_o); end
        beat(1'b0, 1'b0);
        checks++; if (occupancy_o !== 3'd4) begin failures++; $display("FAIL occ_overflow_hold got=%0d exp=4", occupancy_o); end
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL occ_overflow_err got=%0b exp=1", err_o); end
        apply_reset();
        out_valid_i = 1'b1;
        tick();
        out_valid_i = 1'b0;
        checks++; if (occupancy_o !== 3'd0) begin failures++; $display("FAIL occ_underflow_hold got=%0d exp=0", occupancy_o); end
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL occ_underflow_err got=%0b exp=1", err_o); end
        beat(1'b0, 1'b0);
        checks++; if (occupancy_o !== 3'd1) begin failures++; $display("FAIL occ_after_err got=%0d exp=1", occupancy_o); end
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL occ_err_sticky got=%0b exp=1", err_o); end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        cfg_valid_i = 1'b1; cfg_enable_i = 4'hA;
        tick();
        cfg_valid_i = 1'b0;
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        checks++; if (state_o !== S_DRAIN) begin failures++; $display("FAIL rst_pre_drain got=%0d exp=%0d", state_o, S_DRAIN); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_async_stall got=%0b exp=0", stall_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%0b exp=0", busy_o); end
        checks++; if (filt_enable_o !== 4'h0) begin failures++; $display("FAIL rst_async_enable got=%h exp=0", filt_enable_o); end
        checks++; if (occupancy_o !== 3'd0) begin failures++; $display("FAIL rst_async_occ got=%0d exp=0", occupancy_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL rst_after_cfg_ready got=%0b exp=1", cfg_ready_o); end
        cfg_valid_i = 1'b1; cfg_enable_i = 4'hC;
        tick();
        cfg_valid_i = 1'b0;
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rst_new_stall got=%0b exp=1", stall_o); end
        checks++; if (occupancy_o !== 3'd2) begin failures++; $display("FAIL rst_new_occ got=%0d exp=2", occupancy_o); end
        out_valid_i = 1'b1;
        repeat (2) tick();
        out_valid_i = 1'b0;
        tick();
        checks++; if (filt_enable_o !== 4'h0) begin failures++; $display("FAIL rst_new_apply got=%h exp=0", filt_enable_o); end
        tick();
        checks++; if (filt_enable_o !== 4'hC) begin failures++; $display("FAIL rst_new_switch got=%h exp=c", filt_enable_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_new_release got=%0b exp=0", stall_o); end
    endtask

    initial begin
        test_reset();
        test_explicit();
        test_auto_cycle();
        test_auto_wrap();
        test_priority();
        test_backpressure();
        test_occupancy();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_filt_sched.md
# rgb_filt_sched

Frame-synchronous filter configuration scheduler for the 4-stage RGB processing pipeline (grayscale, saturator, inverter, contrast adjuster). It accepts new filter-enable requests from software or a demo auto-cycler and holds each request until a frame boundary. At that boundary it stalls the pipeline input, drains in-flight beats with the old configuration, and then switches `filt_enable_o` atomically. No beat is ever processed by a mix of old and new stage settings.

## Interface
- `Depth`, 4: max beats in flight between pipeline input (p0) and output (p4) handshakes; sets occupancy width `$clog2(Depth+1)`.
- `FramesPerMode`, 60: frame boundaries per auto-cycle step; must be ≥1.
- `ResetEnable`, 4'b0000: value of `filt_enable_o` after reset.

- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `cfg_valid_i`  in  1  config request valid.
- `cfg_ready_o`  out  1  config request accepted when both are high.
- `cfg_enable_i`  in  4  requested filter enables, bit n → stage n.
- `auto_en_i`  in  1  enable demo auto-cycling.
- `in_valid_i`  in  1  pipeline p0 valid.
- `in_ready_i`  in  1  pipeline p0 ready, before the stall gating.
- `vsync_i`  in  1  vsync of the beat presented at p0.
- `out_valid_i`  in  1  pipeline p4 valid.
- `out_ready_i`  in  1  pipeline p4 ready.
- `stall_o`  out  1  integration ANDs `~stall_o` into p0 ready.
- `filt_enable_o`  out  4  active filter enables to the pipeline.
- `busy_o`  out  1  a request is pending or being applied.
- `occupancy_o`  out  $clog2(Depth+1)  beats in flight.
- `err_o`  out  1  sticky occupancy overflow/underflow flag.

## Operation
- Handshake fires:
  - `in_fire = in_valid_i & in_ready_i & ~stall_o`
  - `out_fire = out_valid_i & out_ready_i`
- Occupancy counter:
  - +1 on `in_fire` only.
  - −1 on `out_fire` only.
  - Unchanged when both fire together.
  - Increment at `Depth` or decrement at 0: the counter holds and `err_o` sets (sticky until reset).
- Frame boundary (`fb`): an `in_fire` with `vsync_i=1` while `vs_prev=0`.
  - `vs_prev` loads `vsync_i` on every `in_fire`.
  - `vs_prev` resets to 0.
- Registered FSM, states IDLE, ARMED, DRAIN, APPLY:
  - **IDLE**
    - `cfg_ready_o=1`.
    - On `cfg_valid_i`: `pend ← cfg_enable_i`, go to ARMED, clear `frame_cnt`.
    - Otherwise, if `auto_en_i` and `fb`: increment `frame_cnt`.
    - When the incremented value equals `FramesPerMode`: `pend ← filt_enable_o + 1` (4-bit wrap, F→0), clear `frame_cnt`, go to ARMED.
    - An explicit cfg beats auto in the same cycle.
  - **ARMED**
    - `cfg_ready_o=0`.
    - On `fb`, go to DRAIN. The boundary beat itself enters the pipeline under the old config.
  - **DRAIN**
    - `stall_o=1`.
    - When `occupancy==0`, go to APPLY.
  - **APPLY**
    - `stall_o=1`.
    - `filt_enable_o ← pend`, go to IDLE.
- Output decodes:
  - `busy_o = (state != IDLE)`.
  - `stall_o = (state==DRAIN | state==APPLY)`, decoded from state flops only, with no combinational path from inputs.
  - `cfg_ready_o = (state==IDLE)`.
- `frame_cnt` does not count in ARMED, DRAIN or APPLY.
- `auto_en_i` deasserted: `frame_cnt` holds its value; an already-armed request still applies.
- Reset at any point forces these values, discarding any pending request:
  - IDLE, `stall_o=0`, `busy_o=0`, `cfg_ready_o=1` (once out of reset)
  - `filt_enable_o=ResetEnable`
  - `occupancy_o=0`, `err_o=0`, `frame_cnt=0`, `pend=0`, `vs_prev=0`

## Timing
- Request accepted at edge k: ARMED from k+1, so `busy_o=1` from k+1.
- `fb` fire at edge m: DRAIN from m+1, so `stall_o=1` from m+1.
- In-flight beats then drain under the old config.
- First cycle in DRAIN with `occupancy_o==0`, at edge d: APPLY from d+1.
- At edge d+2, all of these happen together:
  - `filt_enable_o` updates
  - state returns to IDLE
  - `stall_o` drops
- The first beat after the switch is accepted at edge d+3 at the earliest, under the new config.
- Minimum stall is 2 cycles (DRAIN+APPLY). The boundary beat always makes occupancy ≥1 at DRAIN entry, so DRAIN lasts ≥1 cycle.
- `occupancy_o` is registered and reflects fires at the previous edge.

## Test plan
- **Explicit config:**
  - Stimulus: `cfg_enable_i=4'b1010`, pipeline latency 4. Stream 3 beats with vsync=0, then 1 beat with vsync=1.
  - Response: `stall_o` rises the cycle after the vsync beat. It holds until occupancy reaches 0, plus 1 cycle. `filt_enable_o` goes 0→A exactly as `stall_o` falls. All 4 old beats exit before the switch.
- **Auto-cycle:**
  - Stimulus: `FramesPerMode=2`, `auto_en_i=1`, 6 frames streamed.
  - Response: `filt_enable_o` steps 0→1 (boundary 3), then 1→2 (boundary 6).
  - Wrap case: start at F, which yields 0.
- **Priority:**
  - Stimulus: `cfg_valid_i` in the same cycle as the auto threshold `fb`.
  - Response: `pend` holds the cfg value; `frame_cnt` clears.
- **Backpressure:**
  - Stimulus: `out_ready_i=0` for 10 cycles during DRAIN.
  - Response: `stall_o` stays 1 and `filt_enable_o` stays unchanged. Switch happens 2 cycles after the last `out_fire`.
- **Occupancy:**
  - Stimulus 1: simultaneous in/out fires for 20 cycles. Response: `occupancy_o` constant.
  - Stimulus 2: `out_fire` with occupancy 0. Response: `err_o=1` sticky.
- **Reset mid-DRAIN:**
  - Stimulus: deassert `rst_ni` asynchronously while in DRAIN.
  - Response: immediately `stall_o=0`, `busy_o=0`, `filt_enable_o=ResetEnable`, `occupancy_o=0`. A new request after reset behaves as in the explicit-config case.
